// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shift types, SR bit
// positions, MUL sequencer states and a rotate helper.
package exe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_MUL = 4'b1010;
  localparam logic [3:0] EXE_CMP = 4'b1011;
  localparam logic [3:0] EXE_TST = 4'b1100;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Rotate by 0 returns the operand unchanged (the left term shifts out to 0).
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Combinational second-operand generator: memory offset, rotated immediate,
// or immediate-amount shifted register.
module val2_gen
  import exe_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0] amt;
  logic       unused_reg_shift;

  assign amt              = shift_operand[11:7];
  assign unused_reg_shift = shift_operand[4];

  always_comb begin
    val2 = val_rm;
    if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << amt;
        SH_LSR:  val2 = val_rm >> amt;
        SH_ASR:  val2 = 32'($signed(val_rm) >>> amt);
        default: val2 = ror32(val_rm, amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2, ALU, NZCV register, branch resolve and EXE/MEM register.
// Optional iterative multiplier enabled by defining EXE_STAGE_MUL_EN.
//
// MUL sequencer states (EXE_STAGE_MUL_EN only):
//   state    | meaning
//   MUL_IDLE | no multiply in flight; a MUL arriving here loads first partial product
//   MUL_BUSY | retiring multiplier chunks; count 0 is the final (capture) cycle
module exe_stage
  import exe_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  logic        flush,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic [3:0]  EXE_CMD_IN,
  input  logic [31:0] PC_IN,
  input  logic [31:0] Val_Rn_IN,
  input  logic [31:0] Val_Rm_IN,
  input  logic [31:0] imm_IN,
  input  logic [11:0] Shift_operand_IN,
  input  logic [23:0] Signed_imm_24_IN,
  input  logic [3:0]  Dest_IN,
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic        stall_out,
  output logic [3:0]  SR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] Val_Rm,
  output logic [3:0]  Dest
);

  logic [31:0] val2;
  logic [32:0] sum;
  logic [31:0] alu_res, cap_res;
  logic        alu_c, alu_v, cap_c, cap_v;
  logic        arith, no_wb, op_nop, bubble;
  logic [3:0]  sr_nx;
  logic        unused_imm;

  assign unused_imm = ^imm_IN[31:1];

  val2_gen u_val2 (
    .val_rm        (Val_Rm_IN),
    .shift_operand (Shift_operand_IN),
    .imm           (imm_IN[0]),
    .mem_en        (MEM_R_EN_IN | MEM_W_EN_IN),
    .val2          (val2)
  );

  assign Br_taken = B_IN & ~flush & ~mem_stall;
  assign Br_addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

  // Unassigned opcodes (and MUL when the multiplier is absent) become bubbles.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = SR[SR_C];
    alu_v   = SR[SR_V];
    arith   = 1'b0;
    no_wb   = 1'b0;
    op_nop  = 1'b0;
    case (EXE_CMD_IN)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_ADD, EXE_ADC: begin
        sum   = {1'b0, Val_Rn_IN} + {1'b0, val2} +
                ((EXE_CMD_IN == EXE_ADC) ? {32'b0, SR[SR_C]} : 33'd0);
        arith = 1'b1;
        alu_v = (Val_Rn_IN[31] == val2[31]) && (sum[31] != Val_Rn_IN[31]);
      end
      EXE_SUB, EXE_CMP, EXE_SBC: begin
        sum   = {1'b0, Val_Rn_IN} + {1'b0, ~val2} +
                ((EXE_CMD_IN == EXE_SBC) ? {32'b0, SR[SR_C]} : 33'd1);
        arith = 1'b1;
        alu_v = (Val_Rn_IN[31] != val2[31]) && (sum[31] != Val_Rn_IN[31]);
        no_wb = (EXE_CMD_IN == EXE_CMP);
      end
      EXE_AND, EXE_TST: begin
        alu_res = Val_Rn_IN & val2;
        no_wb   = (EXE_CMD_IN == EXE_TST);
      end
      EXE_ORR: alu_res = Val_Rn_IN | val2;
      EXE_EOR: alu_res = Val_Rn_IN ^ val2;
      default: op_nop = 1'b1;
    endcase
    if (arith) begin
      alu_res = sum[31:0];
      alu_c   = sum[32];
    end
  end

`ifdef EXE_STAGE_MUL_EN
  localparam int MUL_LAT = 32 / MUL_BITS_PER_CYCLE;
  localparam int CNT_W   = $clog2(MUL_LAT) + 1;

  mul_state_e       mul_state, mul_state_nx;
  logic [CNT_W-1:0] mul_cnt, mul_cnt_nx;
  logic [31:0]      acc, acc_nx, mcand, mcand_nx, mplier, mplier_nx;
  logic [31:0]      step, mul_res;
  logic             mul_stall, mul_done, is_mul;

  assign is_mul = (EXE_CMD_IN == EXE_MUL);

  always_comb begin
    mul_state_nx = mul_state;
    mul_cnt_nx   = mul_cnt;
    acc_nx       = acc;
    mcand_nx     = mcand;
    mplier_nx    = mplier;
    mul_stall    = 1'b0;
    mul_done     = 1'b0;
    step         = mcand * {{(32-MUL_BITS_PER_CYCLE){1'b0}}, mplier[MUL_BITS_PER_CYCLE-1:0]};
    mul_res      = acc + step;
    case (mul_state)
      MUL_IDLE: begin
        if (is_mul && !flush) begin
          mul_stall    = 1'b1;
          mul_state_nx = MUL_BUSY;
          mul_cnt_nx   = CNT_W'(MUL_LAT - 2);
          acc_nx       = Val_Rn_IN *
                         {{(32-MUL_BITS_PER_CYCLE){1'b0}}, Val_Rm_IN[MUL_BITS_PER_CYCLE-1:0]};
          mcand_nx     = Val_Rn_IN << MUL_BITS_PER_CYCLE;
          mplier_nx    = Val_Rm_IN >> MUL_BITS_PER_CYCLE;
        end
      end
      MUL_BUSY: begin
        if (flush) begin
          mul_state_nx = MUL_IDLE;
        end else if (mul_cnt == '0) begin
          mul_done     = 1'b1;
          mul_state_nx = MUL_IDLE;
        end else begin
          mul_stall  = 1'b1;
          mul_cnt_nx = mul_cnt - CNT_W'(1);
          acc_nx     = mul_res;
          mcand_nx   = mcand << MUL_BITS_PER_CYCLE;
          mplier_nx  = mplier >> MUL_BITS_PER_CYCLE;
        end
      end
      default: mul_state_nx = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else if (!mem_stall) begin
      mul_state <= mul_state_nx;
      mul_cnt   <= mul_cnt_nx;
      acc       <= acc_nx;
      mcand     <= mcand_nx;
      mplier    <= mplier_nx;
    end
  end

  assign stall_out = mul_stall;
`else
  localparam int unused_mul_bits = MUL_BITS_PER_CYCLE;
  assign stall_out = 1'b0;
`endif

  always_comb begin
    bubble  = B_IN | op_nop;
    cap_res = alu_res;
    cap_c   = alu_c;
    cap_v   = alu_v;
`ifdef EXE_STAGE_MUL_EN
    // Multiply updates only N/Z; C and V keep their previous values.
    if (mul_done) begin
      bubble  = B_IN;
      cap_res = mul_res;
      cap_c   = SR[SR_C];
      cap_v   = SR[SR_V];
    end
`endif
    sr_nx = {cap_res[31], cap_res == 32'd0, cap_c, cap_v};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SR       <= '0;
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      MEM_W_EN <= 1'b0;
      ALU_Res  <= '0;
      Val_Rm   <= '0;
      Dest     <= '0;
    end else if (!mem_stall) begin
      if (flush || bubble) begin
        WB_EN    <= 1'b0;
        MEM_R_EN <= 1'b0;
        MEM_W_EN <= 1'b0;
        ALU_Res  <= '0;
        Val_Rm   <= '0;
        Dest     <= '0;
      end else begin
        WB_EN    <= WB_EN_IN & ~no_wb;
        MEM_R_EN <= MEM_R_EN_IN;
        MEM_W_EN <= MEM_W_EN_IN;
        ALU_Res  <= cap_res;
        Val_Rm   <= Val_Rm_IN;
        Dest     <= Dest_IN;
      end
      if (S_IN && !flush && !bubble) SR <= sr_nx;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table for the ALU/Val2 paths plus
// directed sequences for reset, branch, stall/flush and the optional multiplier.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, mem_stall, flush;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN;
  logic [3:0]  EXE_CMD_IN, Dest_IN;
  logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic        Br_taken, stall_out, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] Br_addr, ALU_Res, Val_Rm;
  logic [3:0]  SR, Dest;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [4:0]  ctl;   // {S, I, MEM_R, MEM_W, WB}
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] so;
    logic [31:0] exp_res;
    logic        exp_wb;
    logic [3:0]  exp_sr;
  } vec_t;

  vec_t vq[$];

  exe_stage dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
    .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
    .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
    .Dest_IN(Dest_IN), .Br_taken(Br_taken), .Br_addr(Br_addr), .stall_out(stall_out),
    .SR(SR), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] cmd, input logic [4:0] ctl, input logic [31:0] rn,
                      input logic [31:0] rm, input logic [11:0] so, input logic [31:0] er,
                      input logic ewb, input logic [3:0] esr);
    vec_t v;
    v.cmd = cmd; v.ctl = ctl; v.rn = rn; v.rm = rm; v.so = so;
    v.exp_res = er; v.exp_wb = ewb; v.exp_sr = esr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [4:0] ctl, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [11:0] so, input logic [3:0] dst);
    EXE_CMD_IN       = cmd;
    S_IN             = ctl[4];
    imm_IN           = {31'h0, ctl[3]};
    MEM_R_EN_IN      = ctl[2];
    MEM_W_EN_IN      = ctl[1];
    WB_EN_IN         = ctl[0];
    Val_Rn_IN        = rn;
    Val_Rm_IN        = rm;
    Shift_operand_IN = so;
    Dest_IN          = dst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0; B_IN = 1'b0;
    PC_IN = 32'h0; Signed_imm_24_IN = 24'h0;
    drive(EXE_ADD, 5'b10001, 32'h5, 32'h6, 12'h0, 4'h3);

    // Sequence is order-dependent: expected SR chains from one vector to the next.
    addv(EXE_ADD, 5'b10001, 32'h7FFFFFFF, 32'h1,        12'h000, 32'h80000000, 1'b1, 4'b1001);
    addv(EXE_MOV, 5'b01001, 32'h0,        32'h0,        12'h4FF, 32'hFF000000, 1'b1, 4'b1001);
    addv(EXE_CMP, 5'b10001, 32'h5,        32'h5,        12'h000, 32'h00000000, 1'b0, 4'b0110);
    addv(EXE_SBC, 5'b00001, 32'd10,       32'd3,        12'h000, 32'h00000007, 1'b1, 4'b0110);
    addv(EXE_SUB, 5'b10001, 32'd3,        32'd5,        12'h000, 32'hFFFFFFFE, 1'b1, 4'b1000);
    addv(EXE_ADC, 5'b10001, 32'd1,        32'd1,        12'h000, 32'h00000002, 1'b1, 4'b0000);
    addv(EXE_MVN, 5'b10001, 32'h0,        32'h0,        12'h000, 32'hFFFFFFFF, 1'b1, 4'b1000);
    addv(EXE_ORR, 5'b00001, 32'h0,        32'h1,        12'h200, 32'h00000010, 1'b1, 4'b1000);
    addv(EXE_EOR, 5'b10001, 32'hFFFFFFFF, 32'h80000000, 12'h240, 32'h07FFFFFF, 1'b1, 4'b0000);
    addv(EXE_AND, 5'b00001, 32'hFFFFFFFF, 32'h12345678, 12'h460, 32'h78123456, 1'b1, 4'b0000);
    addv(EXE_ADD, 5'b00001, 32'h0,        32'h80000000, 12'hFA0, 32'h00000001, 1'b1, 4'b0000);
    addv(EXE_ADD, 5'b00101, 32'h1000,     32'hCAFE0000, 12'hFFC, 32'h00001FFC, 1'b1, 4'b0000);
    addv(EXE_ADD, 5'b00010, 32'h20,       32'hDEADBEEF, 12'h004, 32'h00000024, 1'b0, 4'b0000);
    addv(EXE_TST, 5'b10001, 32'hF0,       32'h0F,       12'h000, 32'h00000000, 1'b0, 4'b0100);
    addv(EXE_SUB, 5'b10001, 32'h80000000, 32'h1,        12'h000, 32'h7FFFFFFF, 1'b1, 4'b0011);
    addv(EXE_ADC, 5'b10001, 32'hFFFFFFFF, 32'h0,        12'h000, 32'h00000000, 1'b1, 4'b0110);
    addv(EXE_SBC, 5'b10001, 32'd5,        32'd2,        12'h000, 32'h00000003, 1'b1, 4'b0010);

    // Reset holds every registered output at zero despite live inputs.
    @(negedge clk); @(negedge clk);
    chk("rst_wb", 32'(WB_EN), 32'd0);
    chk("rst_res", ALU_Res, 32'd0);
    chk("rst_sr", 32'(SR), 32'd0);
    chk("rst_dest", 32'(Dest), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].cmd, vq[k].ctl, vq[k].rn, vq[k].rm, vq[k].so, 4'(k));
      @(negedge clk);
      chk($sformatf("v%0d_res", k), ALU_Res, vq[k].exp_res);
      chk($sformatf("v%0d_wb", k), 32'(WB_EN), 32'(vq[k].exp_wb));
      chk($sformatf("v%0d_sr", k), 32'(SR), 32'(vq[k].exp_sr));
      chk($sformatf("v%0d_memr", k), 32'(MEM_R_EN), 32'(vq[k].ctl[2]));
      chk($sformatf("v%0d_memw", k), 32'(MEM_W_EN), 32'(vq[k].ctl[1]));
      chk($sformatf("v%0d_valrm", k), Val_Rm, vq[k].rm);
      chk($sformatf("v%0d_dest", k), 32'(Dest), 32'(k[3:0]));
    end

    // Branch: combinational redirect, suppressed by stall/flush, bubble to MEM.
    drive(EXE_ADD, 5'b00001, 32'h55, 32'h0, 12'h0, 4'h5);
    B_IN = 1'b1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE;
    #1 chk("br_taken", 32'(Br_taken), 32'd1);
    chk("br_addr_back", Br_addr, 32'hF8);
    mem_stall = 1'b1;
    #1 chk("br_stall", 32'(Br_taken), 32'd0);
    mem_stall = 1'b0; flush = 1'b1;
    #1 chk("br_flush", 32'(Br_taken), 32'd0);
    flush = 1'b0; PC_IN = 32'h200; Signed_imm_24_IN = 24'h000010;
    #1 chk("br_addr_fwd", Br_addr, 32'h240);
    @(negedge clk);
    chk("br_bubble_wb", 32'(WB_EN), 32'd0);
    chk("br_bubble_res", ALU_Res, 32'd0);
    chk("br_bubble_dest", 32'(Dest), 32'd0);
    chk("br_sr", 32'(SR), 32'b0010);
    B_IN = 1'b0;

    // mem_stall holds outputs and SR (also against a simultaneous flush), then flush bubbles.
    drive(EXE_ADD, 5'b00001, 32'h1, 32'h1, 12'h0, 4'h3);
    @(negedge clk);
    chk("pre_stall_res", ALU_Res, 32'd2);
    drive(EXE_ADD, 5'b10001, 32'h0, 32'h0, 12'h0, 4'h9);
    mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) flush = 1'b1;
      @(negedge clk);
      chk($sformatf("stall%0d_res", c), ALU_Res, 32'd2);
      chk($sformatf("stall%0d_dest", c), 32'(Dest), 32'd3);
      chk($sformatf("stall%0d_sr", c), 32'(SR), 32'b0010);
    end
    mem_stall = 1'b0;
    @(negedge clk);
    chk("flush_wb", 32'(WB_EN), 32'd0);
    chk("flush_res", ALU_Res, 32'd0);
    chk("flush_dest", 32'(Dest), 32'd0);
    chk("flush_sr", 32'(SR), 32'b0010);
    flush = 1'b0;

`ifdef EXE_STAGE_MUL_EN
    // 6*7 with 4 bits/cycle: seven stall cycles, result on the eighth edge.
    drive(EXE_MUL, 5'b10001, 32'd6, 32'd7, 12'h0, 4'h4);
    n = 0;
    #1;
    while (stall_out && n < 20) begin
      n++;
      @(negedge clk); #1;
      if (n == 2) chk("mul_bubble_wb", 32'(WB_EN), 32'd0);
    end
    chk("mul_stall_cycles", 32'(n), 32'd7);
    @(negedge clk);
    chk("mul_res", ALU_Res, 32'd42);
    chk("mul_wb", 32'(WB_EN), 32'd1);
    chk("mul_sr", 32'(SR), 32'b0010);
    drive(EXE_MUL, 5'b00001, 32'd3, 32'd5, 12'h0, 4'h6);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("mul_flush_wb", 32'(WB_EN), 32'd0);
    chk("mul_flush_res", ALU_Res, 32'd0);
    flush = 1'b0;
    drive(EXE_MOV, 5'b01001, 32'h0, 32'h0, 12'h0AB, 4'h2);
    #1 chk("mul_flush_idle", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("post_mul_mov", ALU_Res, 32'hAB);
`else
    // Without the multiplier, opcode 1010 is a bubble that leaves SR alone.
    drive(EXE_MUL, 5'b10001, 32'h0, 32'h0, 12'h0, 4'h7);
    #1 chk("nop_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("nop_wb", 32'(WB_EN), 32'd0);
    chk("nop_dest", 32'(Dest), 32'd0);
    chk("nop_sr", 32'(SR), 32'b0010);
    n = 0;
    chk("nop_n", 32'(n), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
